regbank_write_port: RTL

Write-port sequencer sitting directly upstream of the 16 x 32-bit register bank. Accepts register write requests over a valid/ready handshake, buffers up to 4 of them in a FIFO, and drives the bank's one-hot `select` and `Din` inputs with one write per cycle. Also provides a bank-clear sweep that writes zero to all 16 registers in ascending order.

---
 rtl/regbank_write_port.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regbank_write_port.sv
// Write-port sequencer for the 16 x 32-bit register bank.
// Queues write requests in a small FIFO and issues one write per cycle to the
// bank as a one-hot select strobe plus data. A clear request waits for the
// queue to drain, then sweeps zeros into every register in ascending order.
module regbank_write_port #(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_req,
   output logic [NREG-1:0]   select,
   output logic [DATA_W-1:0] Din,
   output logic [2:0]        count,
   output logic              busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [2:0] FULL_CNT = 3'(DEPTH);
   localparam logic [NREG-1:0] ONE_HOT0 = NREG'(1);

   typedef enum logic {
      RUN,
      CLEAR
   } state_t;

   state_t state_q, state_d;
   logic clr_pending_q, clr_pending_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [NREG-1:0] select_q, select_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [2:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

   logic [ADDR_W-1:0] mem_addr_q [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];

   logic push;
   logic pop;

   // Handshake and issue qualifiers; ready ignores any same-cycle pop.
   always_comb begin
      wr_ready = (count_q != FULL_CNT) && !clr_pending_q && (state_q == RUN);
      push     = wr_valid && wr_ready;
      pop      = (state_q == RUN) && (count_q != 3'd0);
   end

   // FIFO pointer and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
         count_d = count_q + 3'd1;
      end else if (!push && pop) begin
         count_d = count_q - 3'd1;
      end
   end

   // Next-state logic: issue queued writes in RUN, sweep zeros in CLEAR.
   always_comb begin
      state_d       = state_q;
      clr_pending_d = clr_pending_q;
      idx_d         = idx_q;
      select_d      = '0;
      din_d         = din_q;
      case (state_q)
         RUN: begin
            if (pop) begin
               select_d = ONE_HOT0 << mem_addr_q[rd_ptr_q];
               din_d    = mem_data_q[rd_ptr_q];
            end
            if (clr_pending_q && (count_q == 3'd0)) begin
               state_d       = CLEAR;
               clr_pending_d = 1'b0;
               idx_d         = '0;
            end else if (clr_req) begin
               clr_pending_d = 1'b1;
            end
         end
         CLEAR: begin
            if (select_q[NREG-1]) begin
               state_d = RUN;
               idx_d   = '0;
            end else begin
               select_d = ONE_HOT0 << idx_q;
               din_d    = '0;
               idx_d    = idx_q + ADDR_W'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   // Control and output registers; reset discards all outstanding work.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= RUN;
         clr_pending_q <= 1'b0;
         idx_q         <= '0;
         select_q      <= '0;
         din_q         <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         clr_pending_q <= clr_pending_d;
         idx_q         <= idx_d;
         select_q      <= select_d;
         din_q         <= din_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are only meaningful behind valid pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_addr_q[wr_ptr_q] <= wr_addr;
         mem_data_q[wr_ptr_q] <= wr_data;
      end
   end

   // Status outputs derived from registered state.
   always_comb begin
      select = select_q;
      Din    = din_q;
      count  = count_q;
      busy   = (count_q != 3'd0) || clr_pending_q || (state_q == CLEAR) || (select_q != '0);
   end

endmodule
